regfile32: RTL and testbench

//   32-entry x 32-bit general-purpose register file: one write port, two read ports.

---
 rtl/regfile32_pkg.sv | 13 +
 rtl/regfile32_decoder32.sv | 15 +
 rtl/regfile32.sv | 80 ++++++++
 tb/tb_regfile32.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile32_pkg.sv
// Shared register-file constants for the regfile32 slice.
// Register count, address width, data width and the zero-register index.
package regfile32_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_ZERO   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_sel_t;

endpackage

// File: rtl/regfile32_decoder32.sv
// 5-to-32 one-hot write-address decoder.
// Ports: in = register index, out = one-hot select (bit i set for index i).
module regfile32_decoder32
  import regfile32_pkg::*;
(
  input  reg_addr_t in,
  output reg_sel_t  out
);

  always_comb begin
    out = '0;
    out[in] = 1'b1;
  end

endmodule

// File: rtl/regfile32.sv
// 32 x WIDTH register file, one write port and two combinational read ports.
// Ports: clk/rst (sync, active-high), wr_en/wr_addr/wr_data write port,
// rd_addr_a/rd_data_a and rd_addr_b/rd_data_b read ports,
// wr_sel one-hot of the last committed write (0 if none).
module regfile32
  import regfile32_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b,
  output logic [REG_COUNT-1:0]  wr_sel
);

  localparam reg_addr_t ZERO_IDX = reg_addr_t'(REG_ZERO);

  reg_sel_t         dec;
  reg_sel_t         we;
  logic [WIDTH-1:0] mem [REG_COUNT];
  logic             byp;

  regfile32_decoder32 u_wdec (
    .in  (wr_addr),
    .out (dec)
  );

  // Gating by wr_en keeps an undriven wr_addr from
  // reaching any register while the strobe is low.
  always_comb begin
    we = dec & {REG_COUNT{wr_en}};
    we[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
      wr_sel <= '0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (we[i]) mem[i] <= wr_data;
      end
      wr_sel <= we;
    end
  end

  assign byp = BYPASS && wr_en && !rst;

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != ZERO_IDX) begin
      if (byp && rd_addr_a == wr_addr) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = mem[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != ZERO_IDX) begin
      if (byp && rd_addr_b == wr_addr) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = mem[rd_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: directed scenarios plus random traffic,
// with bypass (BYPASS=1) and non-bypass (BYPASS=0) instances side by side.
module tb_regfile32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] a1, b1, a0, b0;
  logic [31:0] sel1, sel0;

  int tests  = 0;
  int failed = 0;

  logic [31:0] ref_mem [32];
  logic [31:0] ref_sel;

  always #5 clk = ~clk;

  regfile32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (a1),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (b1),
    .wr_sel    (sel1)
  );

  regfile32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (a0),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (b0),
    .wr_sel    (sel0)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ad,
                                         input bit byp);
    if (ad == 5'd0) return 32'h0;
    if (byp && wr_en && !rst && ad == wr_addr) return wr_data;
    return ref_mem[ad];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, " a1"}, a1, exp_rd(rd_addr_a, 1'b1));
    check({tag, " b1"}, b1, exp_rd(rd_addr_b, 1'b1));
    check({tag, " a0"}, a0, exp_rd(rd_addr_a, 1'b0));
    check({tag, " b0"}, b0, exp_rd(rd_addr_b, 1'b0));
  endtask

  task automatic check_sel(input string tag);
    check({tag, " sel1"}, sel1, ref_sel);
    check({tag, " sel0"}, sel0, ref_sel);
  endtask

  // Sample inputs, advance the model, cross the edge, settle.
  task automatic tick();
    logic [31:0] nsel;
    nsel = '0;
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      ref_mem[wr_addr] = wr_data;
      nsel[wr_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    ref_sel = nsel;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      check_reads($sformatf("%s r%0d", tag, i));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'hxxxx_xxxx;
    ref_sel   = 32'hxxxx_xxxx;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_all("reset");
    check_sel("reset");

    // r5 write, visible next cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    rd_addr_a = 5'd5;
    #1;
    check("r5 read", a1, 32'hDEADBEEF);
    check("r5 read nb", a0, 32'hDEADBEEF);
    check("r5 sel", sel1, 32'h0000_0020);

    // r0 write is a no-op
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    check_reads("r0 byp");
    tick();
    wr_en = 1'b0;
    #1;
    check("r0 read", a1, 32'h0);
    check("r0 sel", sel1, 32'h0);
    check_all("after r0");

    // same-cycle bypass on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    check("byp a", a1, 32'h12345678);
    check("byp b", b1, 32'h12345678);
    check("nobyp a", a0, 32'h0);
    check("nobyp b", b0, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("nobyp a next", a0, 32'h12345678);
    check("nobyp b next", b0, 32'h12345678);

    // extreme indices on consecutive cycles
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
    tick();
    check("r31 sel", sel1, 32'h8000_0000);
    wr_addr = 5'd1; wr_data = 32'h5A5A5A5A;
    tick();
    check("r1 sel", sel1, 32'h0000_0002);
    wr_en = 1'b0;
    rd_addr_a = 5'd31; rd_addr_b = 5'd1;
    #1;
    check("r31 a", a1, 32'hA5A5A5A5);
    check("r1 b", b1, 32'h5A5A5A5A);
    check_all("edges");

    // back-to-back same index: last wins
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1111_1111;
    tick();
    wr_data = 32'h2222_2222;
    tick();
    wr_en = 1'b0;
    rd_addr_a = 5'd12;
    #1;
    check("b2b r12", a1, 32'h2222_2222);

    // unknown address with strobe low
    wr_addr = 5'bxxxxx; wr_data = 32'hBAD0_BAD0;
    tick();
    wr_addr = 5'd0;
    check("xaddr sel", sel1, 32'h0);
    check_all("xaddr");

    // reset drops a concurrent write
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1;
    tick();
    rst = 1'b1; wr_data = 32'h99;
    rd_addr_a = 5'd10; rd_addr_b = 5'd10;
    #1;
    check_reads("rst byp");
    tick();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("rst r10", a1, 32'h0);
    check("rst sel", sel1, 32'h0);
    check_all("rst drop");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 31) == 0);
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      #1;
      check_reads($sformatf("rnd%0d", n));
      tick();
      check_sel($sformatf("rnd%0d", n));
    end
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
